// File: rtl/rams_pkg.sv
// rams_pkg: shared read-during-write constants and sweep state type
package rams_pkg;
  localparam int RDW_READ_FIRST = 0;
  localparam int RDW_WRITE_FIRST = 1;
  localparam int RDW_NO_CHANGE = 2;
  typedef enum logic {IDLE, CLEAR} sweep_state_t;
endpackage

// File: rtl/bram_sweep_ctrl.sv
// bram_sweep_ctrl: clear-sweep FSM, address counter and memory write-port mux
module bram_sweep_ctrl
  import rams_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter logic [DW-1:0] CLR_VAL = '0,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   di_i,
  output logic            busy_o,
  output logic            acc_o,
  output logic [DW/8-1:0] mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_di_o
);
  sweep_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic start_q;
  // start_q remembers that the first clock after reset release must launch a sweep
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      start_q <= CLR_ON_RST != 0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      start_q <= 1'b0;
    end
  // sweep ends after writing the last address; the counter wraps back to 0 by itself
  always_comb begin
    state_d = state_q == IDLE ? ((start_q || clr_i) ? CLEAR : IDLE) : (&cnt_q ? IDLE : CLEAR);
    cnt_d = state_q == CLEAR ? cnt_q + AW'(1) : cnt_q;
  end
  assign busy_o = state_q == CLEAR;
  assign acc_o = en_i & ~busy_o;
  assign mem_we_o = busy_o ? '1 : (acc_o ? we_i : '0);
  assign mem_addr_o = busy_o ? cnt_q : addr_i;
  assign mem_di_o = busy_o ? CLR_VAL : di_i;
endmodule

// File: rtl/bram_sweep_clear.sv
// bram_sweep_clear: byte-lane block RAM with RDW modes, output stages and clear sweep
module bram_sweep_clear
  import rams_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 7,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG = 0,
  parameter logic [DW-1:0] RST_VAL = '0,
  parameter logic [DW-1:0] CLR_VAL = '0,
  parameter int CLR_ON_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW/8-1:0] we,
  input  logic            srst,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   di,
  output logic [DW-1:0]   dout,
  output logic            rvalid,
  input  logic            clr,
  output logic            busy
);
  logic [DW-1:0] mem [2**AW];
  logic acc, acc_q, rv1_q, rv2_q;
  logic [DW/8-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di, old_w, merged, s1_d, s1_q, s2_q;
  bram_sweep_ctrl #(.DW(DW), .AW(AW), .CLR_VAL(CLR_VAL), .CLR_ON_RST(CLR_ON_RST)) u_ctrl (
    .clk(clk),
    .rst(rst),
    .en_i(en),
    .clr_i(clr),
    .we_i(we),
    .addr_i(addr),
    .di_i(di),
    .busy_o(busy),
    .acc_o(acc),
    .mem_we_o(mem_we),
    .mem_addr_o(mem_addr),
    .mem_di_o(mem_di)
  );
  // byte-lane write port; deliberately no reset so the array stays a block RAM
  always_ff @(posedge clk)
    for (int i = 0; i < DW/8; i++)
      if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_di[8*i +: 8];
  assign old_w = mem[addr];
  // word as it will look after this write: new bytes on enabled lanes, old bytes elsewhere
  always_comb begin
    merged = old_w;
    for (int i = 0; i < DW/8; i++)
      if (we[i]) merged[8*i +: 8] = di[8*i +: 8];
  end
  assign s1_d = !acc ? s1_q
              : srst ? RST_VAL
              : (RDW_MODE == RDW_NO_CHANGE && |we) ? s1_q
              : RDW_MODE == RDW_WRITE_FIRST ? merged : old_w;
  // output stages and the read-valid pipeline that travels alongside them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      acc_q <= 1'b0;
      rv1_q <= 1'b0;
      rv2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= acc_q ? s1_q : s2_q;
      acc_q <= acc;
      rv1_q <= acc & (~|we | srst);
      rv2_q <= rv1_q;
    end
  assign dout = OUT_REG != 0 ? s2_q : s1_q;
  assign rvalid = OUT_REG != 0 ? rv2_q : rv1_q;
endmodule

// File: tb/tb_bram_sweep_clear.sv
// tb_bram_sweep_clear: table and scoreboard checks over three RDW/latency configurations
module tb_bram_sweep_clear;
  import rams_pkg::*;
  localparam logic [15:0] RV = 16'h0BAD;
  localparam logic [15:0] CV = 16'hA5A5;
  typedef struct {
    int due;
    logic [15:0] val;
  } exp_t;
  typedef struct {
    logic en;
    logic [1:0] we;
    logic srst;
    logic [6:0] addr;
    logic [15:0] di;
    logic rv;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, srst = 1'b0, clr = 1'b0;
  logic [1:0] we = 2'b00;
  logic [6:0] addr = 7'd0;
  logic [15:0] di = 16'h0;
  logic [15:0] dout [3];
  logic rv [3];
  logic bsy [3];
  exp_t q [3][$];
  int lat [3] = '{2, 1, 1};
  int cyc = 0, pass = 0, total = 0;
  vec_t tbl [23];
  always #5 clk = ~clk;
  bram_sweep_clear #(.DW(16), .AW(7), .RDW_MODE(RDW_READ_FIRST), .OUT_REG(1), .RST_VAL(RV), .CLR_VAL(CV), .CLR_ON_RST(1)) u_rf (
    .clk(clk), .rst(rst), .en(en), .we(we), .srst(srst), .addr(addr), .di(di),
    .dout(dout[0]), .rvalid(rv[0]), .clr(clr), .busy(bsy[0]));
  bram_sweep_clear #(.DW(16), .AW(7), .RDW_MODE(RDW_WRITE_FIRST), .OUT_REG(0), .RST_VAL(RV), .CLR_VAL(CV), .CLR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst), .en(en), .we(we), .srst(srst), .addr(addr), .di(di),
    .dout(dout[1]), .rvalid(rv[1]), .clr(clr), .busy(bsy[1]));
  bram_sweep_clear #(.DW(16), .AW(7), .RDW_MODE(RDW_NO_CHANGE), .OUT_REG(0), .RST_VAL(RV), .CLR_VAL(CV), .CLR_ON_RST(1)) u_nc (
    .clk(clk), .rst(rst), .en(en), .we(we), .srst(srst), .addr(addr), .di(di),
    .dout(dout[2]), .rvalid(rv[2]), .clr(clr), .busy(bsy[2]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) pass++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++)
      if (rv[k]) begin
        if (q[k].size() == 0) chk($sformatf("rvalid_spurious[%0d] cyc=%0d", k, cyc), 32'(rv[k]), 32'd0);
        else begin
          e = q[k].pop_front();
          chk($sformatf("rd_data[%0d] cyc=%0d", k, cyc), 32'(dout[k]), 32'(e.val));
          chk($sformatf("rd_cycle[%0d]", k), cyc, e.due);
        end
      end
  endtask
  task automatic push(input logic [15:0] v);
    for (int k = 0; k < 3; k++) q[k].push_back('{cyc + lat[k], v});
  endtask
  task automatic drive(input logic e, input logic [1:0] w, input logic s, input logic [6:0] a, input logic [15:0] d);
    en = e;
    we = w;
    srst = s;
    addr = a;
    di = d;
  endtask
  task automatic drain(input string tag);
    drive(1'b0, 2'b00, 1'b0, 7'd0, 16'h0);
    repeat (3) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("%s_sb_empty[%0d]", tag, k), q[k].size(), 0);
  endtask
  task automatic sweep_run();
    int nb [3];
    int g;
    nb = '{0, 0, 0};
    g = 0;
    do begin
      tick();
      g++;
      if (g == 1) for (int k = 0; k < 3; k++) chk($sformatf("busy_rise[%0d]", k), 32'(bsy[k]), 32'd1);
      for (int k = 0; k < 3; k++) if (bsy[k]) nb[k]++;
      clr = g == 20;
      if (g >= 30 && g < 35) drive(1'b1, 2'b11, 1'b0, 7'd10, 16'hDEAD);
      else if (g >= 35 && g < 37) drive(1'b1, 2'b00, 1'b1, 7'd10, 16'h0);
      else drive(1'b0, 2'b00, 1'b0, 7'd0, 16'h0);
    end while ((bsy[0] || bsy[1] || bsy[2]) && g < 300);
    clr = 1'b0;
    for (int k = 0; k < 3; k++) chk($sformatf("sweep_len[%0d]", k), nb[k], 128);
  endtask
  initial begin
    tbl = '{
      '{1'b1, 2'd0, 1'b0, 7'd0,   16'h0,    1'b1, CV},
      '{1'b1, 2'd0, 1'b0, 7'd64,  16'h0,    1'b1, CV},
      '{1'b1, 2'd0, 1'b0, 7'd127, 16'h0,    1'b1, CV},
      '{1'b1, 2'd3, 1'b0, 7'd5,   16'h1234, 1'b0, 16'h0},
      '{1'b1, 2'd2, 1'b0, 7'd5,   16'hAB00, 1'b0, 16'h0},
      '{1'b1, 2'd0, 1'b0, 7'd5,   16'h0,    1'b1, 16'hAB34},
      '{1'b1, 2'd3, 1'b0, 7'd9,   16'h1111, 1'b0, 16'h0},
      '{1'b1, 2'd3, 1'b0, 7'd0,   16'h0100, 1'b0, 16'h0},
      '{1'b1, 2'd3, 1'b0, 7'd1,   16'h0101, 1'b0, 16'h0},
      '{1'b1, 2'd3, 1'b0, 7'd2,   16'h0102, 1'b0, 16'h0},
      '{1'b1, 2'd3, 1'b0, 7'd3,   16'h0103, 1'b0, 16'h0},
      '{1'b1, 2'd0, 1'b0, 7'd0,   16'h0,    1'b1, 16'h0100},
      '{1'b1, 2'd0, 1'b0, 7'd1,   16'h0,    1'b1, 16'h0101},
      '{1'b1, 2'd0, 1'b0, 7'd2,   16'h0,    1'b1, 16'h0102},
      '{1'b1, 2'd0, 1'b0, 7'd3,   16'h0,    1'b1, 16'h0103},
      '{1'b1, 2'd3, 1'b1, 7'd3,   16'hFFFF, 1'b1, RV},
      '{1'b1, 2'd0, 1'b0, 7'd3,   16'h0,    1'b1, 16'hFFFF},
      '{1'b1, 2'd1, 1'b0, 7'd2,   16'h00CD, 1'b0, 16'h0},
      '{1'b1, 2'd0, 1'b0, 7'd2,   16'h0,    1'b1, 16'h01CD},
      '{1'b1, 2'd0, 1'b1, 7'd1,   16'h0,    1'b1, RV},
      '{1'b0, 2'd3, 1'b0, 7'd1,   16'hEEEE, 1'b0, 16'h0},
      '{1'b0, 2'd0, 1'b0, 7'd1,   16'h0,    1'b0, 16'h0},
      '{1'b1, 2'd0, 1'b0, 7'd1,   16'h0,    1'b1, 16'h0101}
    };
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_dout[%0d]", k), 32'(dout[k]), 32'(RV));
      chk($sformatf("rst_rvalid[%0d]", k), 32'(rv[k]), 32'd0);
      chk($sformatf("rst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
    end
    rst = 1'b0;
    sweep_run();
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].en, tbl[i].we, tbl[i].srst, tbl[i].addr, tbl[i].di);
      if (tbl[i].rv) push(tbl[i].exp);
      tick();
    end
    drain("table");
    drive(1'b1, 2'b00, 1'b0, 7'd64, 16'h0);
    push(CV);
    tick();
    drive(1'b1, 2'b11, 1'b0, 7'd9, 16'h2222);
    tick();
    drive(1'b0, 2'b00, 1'b0, 7'd0, 16'h0);
    tick();
    chk("rdw_read_first", 32'(dout[0]), 32'h1111);
    chk("rdw_write_first", 32'(dout[1]), 32'h2222);
    chk("rdw_no_change", 32'(dout[2]), 32'(CV));
    drive(1'b1, 2'b00, 1'b0, 7'd9, 16'h0);
    push(16'h2222);
    tick();
    drain("rdw");
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 3; k++) chk($sformatf("clr_busy[%0d]", k), 32'(bsy[k]), 32'd1);
    repeat (40) tick();
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midrst_dout[%0d]", k), 32'(dout[k]), 32'(RV));
      chk($sformatf("midrst_rvalid[%0d]", k), 32'(rv[k]), 32'd0);
      chk($sformatf("midrst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
    end
    repeat (2) tick();
    for (int k = 0; k < 3; k++) chk($sformatf("held_rst_busy[%0d]", k), 32'(bsy[k]), 32'd0);
    rst = 1'b0;
    sweep_run();
    drive(1'b1, 2'b00, 1'b0, 7'd10, 16'h0);
    push(CV);
    tick();
    drive(1'b1, 2'b00, 1'b0, 7'd9, 16'h0);
    push(CV);
    tick();
    drive(1'b1, 2'b00, 1'b0, 7'd40, 16'h0);
    push(CV);
    tick();
    drain("final");
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/bram_sweep_clear.md
# bram_sweep_clear

Parametrised single-port block RAM with byte-lane write enables, a selectable read-during-write mode, an optional second output register and a synchronous output reset. A built-in sweep controller clears every location to a programmable value after reset or on request, with `busy` and `rvalid` status. It is the general-purpose successor to the fixed 128x16 resettable-output RAM and serves as the default on-chip buffer for datapath blocks.

## Interface
- `DW`, 16: data width; must be a multiple of 8.
- `AW`, 7: address width; depth is 2**AW.
- `RDW_MODE`, 0: read-during-write mode. 0 is READ_FIRST, 1 is WRITE_FIRST, 2 is NO_CHANGE.
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds a second output register, giving 2 cycles.
- `RST_VAL`, 0: value loaded into output registers by `rst` or `srst`.
- `CLR_VAL`, 0: value written to memory by the sweep.
- `CLR_ON_RST`, 1: 1 starts a sweep automatically when `rst` deasserts.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  port enable.
- `we`  in  DW/8  byte-lane write enables; lane i writes `di[8i+7:8i]`.
- `srst`  in  1  synchronous output reset, qualified by `en`.
- `addr`  in  AW  address.
- `di`  in  DW  write data.
- `dout`  out  DW  read data.
- `rvalid`  out  1  `dout` holds data for an accepted read.
- `clr`  in  1  single-cycle request to start a sweep.
- `busy`  out  1  sweep in progress; user access is blocked.

## Operation
- An access is accepted when `en=1` and `busy=0`. Accesses while `busy=1` are dropped: no write, no read, no `srst`.
- Write: on an accepted access, each lane with `we[i]=1` is updated. Other lanes keep their old contents.
- Read into stage 1 on every accepted access:
  - If `srst=1`, stage 1 loads `RST_VAL`. This has priority over the read-during-write mode.
  - READ_FIRST: stage 1 loads the old word.
  - WRITE_FIRST: stage 1 loads the merged word (new bytes on written lanes, old bytes elsewhere).
  - NO_CHANGE: stage 1 holds if any `we` bit is set; otherwise it reads.
- Stage 2 exists only when `OUT_REG=1`:
  - Loads stage 1 when an access was accepted on the previous cycle.
  - Otherwise holds.
- `dout` comes from stage 2 when `OUT_REG=1`, else from stage 1.
- `rvalid` pulses high for exactly one cycle, aligned with `dout`, for each accepted access with `we==0`, and for each accepted `srst`.
- Sweep FSM has two states, IDLE and CLEAR:
  - IDLE to CLEAR: on the first clock after `rst` deasserts, if `CLR_ON_RST=1`; or on `clr=1` while in IDLE.
  - In CLEAR: writes `CLR_VAL` to address counter `cnt`, which starts at 0 and increments by 1 per cycle.
  - CLEAR to IDLE: after the write at `cnt = 2**AW-1`. `cnt` then wraps to 0.
  - A sweep therefore takes exactly 2**AW cycles.
  - `clr` received during CLEAR is ignored and does not restart the sweep.
  - `busy=1` exactly while in CLEAR.
- Asynchronous `rst` at any time, including mid-sweep:
  - `dout` = `RST_VAL`, both stages.
  - `rvalid` = 0.
  - `cnt` = 0.
  - FSM goes to IDLE. `busy` reads 0 during reset; if `CLR_ON_RST=1` it rises on the first clock after release.
  - Memory contents are not reset; locations not yet swept keep their data.

## Timing
- Read latency is 1 cycle (`OUT_REG=0`) or 2 cycles (`OUT_REG=1`), measured from the accepting edge to `dout` valid.
- `srst` takes effect at the same latency as a read.
- Back-to-back accesses at full rate: one accepted access per cycle, no bubbles.
- `busy` rises on the edge that enters CLEAR. It falls on the edge after the final sweep write, so the first user access can be accepted that cycle.
- The user must hold the access until `busy=0`. The block provides no back-pressure queue.

## Structure
- Shared package `rams_pkg` contains:
  - RDW mode constants `RDW_READ_FIRST`, `RDW_WRITE_FIRST`, `RDW_NO_CHANGE`.
  - Sweep state enum `sweep_state_t` with values IDLE and CLEAR.
- Sub-module `bram_sweep_ctrl` contains the FSM, counter, `busy` and the sweep write-port mux (sweep address, data and all lanes enabled).
- The top level contains the memory array, the RDW logic, the output stages and `rvalid`.
- The memory array is inferred as block RAM. It must contain no reset term so it still maps to block RAM.

## Test plan
- Power-up sweep (`CLR_ON_RST=1`, `CLR_VAL=16'hA5A5`): release `rst` → `busy` high for exactly 128 cycles; afterwards reads of addresses 0, 64 and 127 return 16'hA5A5 with `rvalid`.
- Byte lanes: write 16'h1234 to address 5, then write `we=2'b10`, `di=16'hAB00` → address 5 reads back 16'hAB34.
- RDW modes: address 9 holds 16'h1111; write 16'h2222 to it with `en=1` → `dout` is 16'h1111 (READ_FIRST), 16'h2222 (WRITE_FIRST), or the previous `dout` unchanged (NO_CHANGE).
- `OUT_REG=1` streaming: read addresses 0 to 3 on consecutive cycles → `dout` and `rvalid` show the same sequence 2 cycles later, with no gaps.
- `srst` together with a write: `srst=1`, `we=2'b11`, `di=16'hFFFF` at address 3 → `dout` = `RST_VAL` and the memory is still updated; a later read of address 3 returns 16'hFFFF.
- Reset mid-sweep: `clr`, then assert `rst` at `cnt`=40 → `dout`=`RST_VAL` and `busy`=0 immediately; after release a new sweep starts from address 0 and runs 128 cycles; an access presented while `busy` is high is dropped.
